iq: RTL and testbench
=====================

// Module: iq
// PURPOSE
//  Instruction queue between decode/ROB-allocate and the issue stage. Circular buffer of
//  iq_entry_t (decoded insn + ROB slot); accepts up to 2 entries/cycle, presents oldest 4
//  in order, retires 1-4 from the head per cycle on issue request. Full flush on redirect.
// PARAMETERS
//  IQ_DEPTHLOG2   4   log2 of entry count (DEPTH = 2**IQ_DEPTHLOG2, min 8)
// PORTS
//  clock         in   1          sole clock, all state on posedge
//  reset         in   1          asynchronous, active-high; clears all state
//  in_valid      in   1 x[2]     decode push strobes, slot 0 older than slot 1
//  in_entry      in   iq_entry_t x[2]  entries to push
//  full          out  1          cannot accept 2 entries this cycle; decode stalls
//  ext_enable    in   1          issue consumes from head this cycle
//  ext_consumed  in   2          number consumed minus 1 (0..3 => 1..4)
//  ext_valid     out  1 x[4]     head window entry k holds a live insn
//  insns         out  iq_entry_t x[4]  head window, insns[0] oldest
//  empty         out  1          count == 0
//  flush         in   1          redirect (new_pc_valid); discard all entries
//  count         out  IQ_DEPTHLOG2+1  live entries (debug/perf)
// BEHAVIOUR
//  - State: storage mem[DEPTH], rd_ptr, wr_ptr (IQ_DEPTHLOG2 bits, wrap mod DEPTH), count.
//  - Reset: rd_ptr=wr_ptr=0, count=0 => empty=1, full=0, ext_valid all 0. mem not reset;
//    insns contents undefined while ext_valid low.
//  - Window: insns[k] = mem[(rd_ptr+k) mod DEPTH], ext_valid[k] = (k < count); pure comb
//    from registers, no bypass: pushed entry first visible the cycle after push.
//  - full = (count > DEPTH-2), from registered count only (pops same cycle not credited).
//  - Push (flush=0, full=0): valid slots written compacted in order at wr_ptr, wr_ptr+1;
//    in_valid[1] alone writes slot 1 at wr_ptr. npush = popcount(in_valid). in_valid while
//    full is dropped (decode must hold); no partial acceptance.
//  - Pop (flush=0): npop = ext_enable ? ext_consumed+1 : 0, saturated to count
//    (over-pop is a protocol error; block never underflows). rd_ptr += npop.
//  - Simultaneous push+pop: count_next = count + npush - npop; both act on pre-cycle state.
//  - Pop of entries beyond what issue saw is impossible: window derived from same regs.
//  - flush=1: count<=0, rd_ptr<=wr_ptr<=0; same-cycle pushes and pops ignored. Next cycle
//    empty=1, all ext_valid=0. Branch + BDS are already in ROB; IQ keeps nothing.
//  - Wrap: window and writes straddle DEPTH-1 -> 0 seamlessly.
//  - Reset asserted mid-operation: immediate (async) return to reset state; outputs
//    settle to reset values without a clock edge.
//  - Invariant: 0 <= count <= DEPTH; wr_ptr == rd_ptr + count mod DEPTH.
// STRUCTURE
//  - iq_entry_t, dec_inst_t already in pipTypes; add IQ_DEPTHLOG2 default constant there
//    so ROB/issue sizing stays consistent.
//  - Single module; no sub-module needed (storage is a flat register array, 2W/4R).
// TESTING
//  1. Reset, no pushes -> empty=1, full=0, count=0, ext_valid=0000 for 5 cycles.
//  2. Push 2/cycle for 8 cycles (DEPTH=16), no pops -> count 2,4..16; full rises when
//     count=15..16 (after 7th push cycle count=14, full=0; after 8th count=16, full=1);
//     insns[0..3] = first 4 pushed, in order.
//  3. Fill 6, then ext_enable=1, ext_consumed=2 with push of 2 same cycle -> count=5,
//     insns[0] = 4th pushed; repeated to force rd_ptr/wr_ptr wrap 15->0, order preserved.
//  4. Count=2, ext_consumed=3 (pop 4) -> count=0, empty=1, no underflow, ptrs equal.
//  5. Count=9 with push+pop asserted, flush=1 -> next cycle count=0, empty=1,
//     ext_valid=0000; following push of 1 appears as insns[0] with ext_valid=1000.
//  6. Assert reset asynchronously mid-burst (between edges) -> empty=1, count=0
//     immediately; after deassert, push resumes from slot 0 correctly.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared pipeline types for the instruction queue: decoded instruction, queue entry, sizing.
package iq_pkg;

    localparam int unsigned IQ_DEPTHLOG2_DEF = 4;
    localparam int unsigned ROB_IDX_W        = 5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [3:0]  op_class;
    } dec_inst_t;

    typedef struct packed {
        dec_inst_t              dec;
        logic [ROB_IDX_W-1:0]   rob_idx;
    } iq_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return 2'(v[0]) + 2'(v[1]);
    endfunction

endpackage

// File: rtl/iq.sv
// Instruction queue: circular buffer between decode/ROB-allocate and issue.
// Pushes up to 2 entries per cycle, exposes the oldest 4, retires 1-4 from the head.
module iq
    import iq_pkg::*;
#(
    parameter int unsigned IQ_DEPTHLOG2 = IQ_DEPTHLOG2_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              in_valid,
    input  iq_entry_t               in_entry [2],
    output logic                    full,
    input  logic                    ext_enable,
    input  logic [1:0]              ext_consumed,
    output logic [3:0]              ext_valid,
    output iq_entry_t               insns [4],
    output logic                    empty,
    input  logic                    flush,
    output logic [IQ_DEPTHLOG2:0]   count
);

    localparam int unsigned DEPTH = 2 ** IQ_DEPTHLOG2;
    localparam int unsigned PW    = IQ_DEPTHLOG2;
    localparam int unsigned CW    = IQ_DEPTHLOG2 + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    iq_entry_t mem [DEPTH];

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    cnt_t count_q, count_d;

    logic push_ok;
    cnt_t npush;
    cnt_t npop;
    cnt_t pop_req;
    ptr_t wr_addr0;
    ptr_t wr_addr1;

    // Full is judged on the registered count only; same-cycle pops earn no credit.
    assign full    = count_q > cnt_t'(DEPTH - 2);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign push_ok = !flush && !full;

    always_comb begin
        npush   = push_ok ? cnt_t'(popcount2(in_valid)) : '0;
        pop_req = cnt_t'(ext_consumed) + cnt_t'(1);
        npop    = '0;
        if (ext_enable) begin
            npop = (pop_req > count_q) ? count_q : pop_req;
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + ptr_t'(npop);
            wr_ptr_d = wr_ptr_q + ptr_t'(npush);
            count_d  = count_q + npush - npop;
        end
    end

    // Valid slots are compacted: a lone slot 1 lands at wr_ptr.
    always_comb begin
        wr_addr0 = wr_ptr_q;
        wr_addr1 = in_valid[0] ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; ext_valid qualifies every window slot.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            if (in_valid[0]) begin
                mem[wr_addr0] <= in_entry[0];
            end
            if (in_valid[1]) begin
                mem[wr_addr1] <= in_entry[1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            insns[k]     = mem[rd_ptr_q + ptr_t'(k)];
            ext_valid[k] = count_q > cnt_t'(k);
        end
    end

endmodule

// File: tb/tb_iq.sv
// Randomised scoreboard bench for iq against a queue-based reference model.
module tb_iq;
    import iq_pkg::*;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] in_valid = 2'b00;
    iq_entry_t  in_entry [2];
    logic       full;
    logic       ext_enable = 1'b0;
    logic [1:0] ext_consumed = 2'b00;
    logic [3:0] ext_valid;
    iq_entry_t  insns [4];
    logic       empty;
    logic       flush = 1'b0;
    logic [4:0] count;

    int total = 0;
    int bad   = 0;
    int seq   = 0;
    bit chk_en = 1'b0;

    iq_entry_t ref_q [$];
    iq_entry_t iss_q [$];
    int        iss_n [$];

    iq #(.IQ_DEPTHLOG2(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_entry     (in_entry),
        .full         (full),
        .ext_enable   (ext_enable),
        .ext_consumed (ext_consumed),
        .ext_valid    (ext_valid),
        .insns        (insns),
        .empty        (empty),
        .flush        (flush),
        .count        (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic iq_entry_t mk_entry();
        iq_entry_t e;
        e.dec.pc       = $urandom;
        e.dec.insn     = $urandom;
        e.dec.rd       = 5'($urandom);
        e.dec.rs       = 5'($urandom);
        e.dec.rt       = 5'($urandom);
        e.dec.op_class = 4'($urandom);
        e.rob_idx      = 5'(seq);
        seq++;
        return e;
    endfunction

    // One clock of stimulus; the reference queue is updated at the edge.
    task automatic cycle(input logic [1:0] v, input logic en, input logic [1:0] cons,
                         input logic fl);
        int n;
        int np;
        bit was_full;
        @(negedge clock);
        in_valid     = v;
        in_entry[0]  = mk_entry();
        in_entry[1]  = mk_entry();
        ext_enable   = en;
        ext_consumed = cons;
        flush        = fl;
        n  = ref_q.size();
        np = 0;
        if (en) np = (int'(cons) + 1 < n) ? int'(cons) + 1 : n;
        if (en && !fl) begin
            iss_n.push_back(np);
            for (int i = 0; i < np; i++) iss_q.push_back(ref_q[i]);
        end
        @(posedge clock);
        if (fl) begin
            ref_q.delete();
        end else begin
            was_full = n > DEPTH - 2;
            repeat (np) void'(ref_q.pop_front());
            if (!was_full) begin
                if (v[0]) ref_q.push_back(in_entry[0]);
                if (v[1]) ref_q.push_back(in_entry[1]);
            end
        end
    endtask

    // Status and head-window monitor, sampled just after each edge.
    always @(posedge clock) begin
        #1;
        if (chk_en && !reset) begin
            chk("count", 128'(count), 128'(ref_q.size()));
            chk("empty", 128'(empty), 128'(ref_q.size() == 0));
            chk("full", 128'(full), 128'(ref_q.size() > DEPTH - 2));
            for (int k = 0; k < 4; k++) begin
                chk("ext_valid", 128'(ext_valid[k]), 128'(k < ref_q.size()));
                if (k < ref_q.size()) chk("insns", 128'(insns[k]), 128'(ref_q[k]));
            end
        end
    end

    // Issue monitor: entries consumed by an issue request must match what was expected.
    always @(negedge clock) begin
        int n;
        iq_entry_t e;
        #1;
        if (ext_enable && !flush && !reset && iss_n.size() > 0) begin
            n = iss_n.pop_front();
            for (int k = 0; k < n; k++) begin
                e = iss_q.pop_front();
                chk("issue_valid", 128'(ext_valid[k]), 128'(1));
                chk("issue_insn", 128'(insns[k]), 128'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_entry[0] = '0;
        in_entry[1] = '0;
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_empty", 128'(empty), 128'(1));
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Idle after reset.
        repeat (5) cycle(2'b00, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t1_ext_valid", 128'(ext_valid), 128'(4'b0000));
        chk("t1_full", 128'(full), 128'(0));

        // Fill at 2/cycle.
        repeat (7) cycle(2'b11, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t2_count14", 128'(count), 128'(14));
        chk("t2_full14", 128'(full), 128'(0));
        cycle(2'b11, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t2_count16", 128'(count), 128'(16));
        chk("t2_full16", 128'(full), 128'(1));
        cycle(2'b11, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t2_drop_when_full", 128'(count), 128'(16));
        cycle(2'b00, 1'b0, 2'd0, 1'b1);

        // Push and pop together, then wrap the pointers.
        repeat (3) cycle(2'b11, 1'b0, 2'd0, 1'b0);
        cycle(2'b11, 1'b1, 2'd2, 1'b0);
        #1;
        chk("t3_count5", 128'(count), 128'(5));
        for (int i = 0; i < 12; i++) cycle(2'b11, ref_q.size() >= 3, 2'd2, 1'b0);

        // Pop 4 with only 2 live.
        cycle(2'b00, 1'b0, 2'd0, 1'b1);
        cycle(2'b11, 1'b0, 2'd0, 1'b0);
        cycle(2'b00, 1'b1, 2'd3, 1'b0);
        #1;
        chk("t4_count0", 128'(count), 128'(0));
        chk("t4_empty", 128'(empty), 128'(1));
        cycle(2'b11, 1'b0, 2'd0, 1'b0);

        // Flush beats same-cycle push and pop.
        cycle(2'b00, 1'b0, 2'd0, 1'b1);
        repeat (4) cycle(2'b11, 1'b0, 2'd0, 1'b0);
        cycle(2'b01, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t5_count9", 128'(count), 128'(9));
        cycle(2'b11, 1'b1, 2'd1, 1'b1);
        #1;
        chk("t5_flush_count", 128'(count), 128'(0));
        chk("t5_flush_valid", 128'(ext_valid), 128'(4'b0000));
        cycle(2'b10, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t5_single_valid", 128'(ext_valid), 128'(4'b0001));

        // Async reset between edges, mid-burst.
        repeat (3) cycle(2'b11, 1'b0, 2'd0, 1'b0);
        @(negedge clock);
        in_valid   = 2'b11;
        ext_enable = 1'b0;
        flush      = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_count", 128'(count), 128'(0));
        chk("t6_empty", 128'(empty), 128'(1));
        chk("t6_ext_valid", 128'(ext_valid), 128'(4'b0000));
        chk("t6_full", 128'(full), 128'(0));
        ref_q.delete();
        in_valid = 2'b00;
        @(negedge clock);
        reset = 1'b0;
        cycle(2'b11, 1'b0, 2'd0, 1'b0);
        cycle(2'b01, 1'b1, 2'd0, 1'b0);

        // Random traffic, including over-pops and occasional flushes.
        for (int i = 0; i < 800; i++) begin
            cycle(2'($urandom), 1'($urandom), 2'($urandom), ($urandom % 32) == 0);
        end
        repeat (2) cycle(2'b00, 1'b0, 2'd0, 1'b0);
        chk("issue_drained", 128'(iss_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
